// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding and arbitration mode constants for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_WRITE} state_t;
  localparam bit ARB_FIXED = 1'b0;
  localparam bit ARB_RR = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and main-memory-side bus of the memory arbiter
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BURST_LEN = 8
);
  logic [NUM_REQ-1:0] req, req_wr, gnt, rsp_valid, done;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rsp_data, mem_wdata, mem_rdata;
  logic [$clog2(BURST_LEN)-1:0] rsp_idx;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_en, mem_wr, mem_valid;
  modport slave (
    input req, req_wr, req_addr, req_wdata, mem_rdata, mem_valid,
    output gnt, rsp_valid, rsp_data, rsp_idx, done, mem_en, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output req, req_wr, req_addr, req_wdata, mem_rdata, mem_valid,
    input gnt, rsp_valid, rsp_data, rsp_idx, done, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter: combinational winner pick, round-robin after the last winner or fixed lowest-index
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter bit RR_MODE = ARB_FIXED,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  int i;
  // Scan from lowest to highest priority so the highest-priority hit is assigned last.
  always_comb begin
    idx = '0;
    valid = 1'b0;
    i = 0;
    for (int k = N - 1; k >= 0; k--) begin
      i = RR_MODE == ARB_RR ? (int'(last) + 1 + k) % N : k;
      if (req[i]) begin
        idx = IW'(i);
        valid = 1'b1;
      end
    end
    gnt = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-requester arbiter sequencing pipelined line fills and single-word write-throughs
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BURST_LEN = 8,
  parameter int WORD_BYTES = 2,
  parameter bit RR_MODE = ARB_FIXED
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BURST_LEN);
  state_t state, state_n;
  logic [NUM_REQ-1:0] owner, win_gnt;
  logic [IW-1:0] last, win_idx;
  logic [CW-1:0] iss_cnt, ret_cnt;
  logic [ADDR_W-1:0] addr, sel_addr;
  logic [DATA_W-1:0] wdata;
  logic win_valid, ret, last_ret;
  rr_arbiter #(.N(NUM_REQ), .RR_MODE(RR_MODE)) u_rr (
    .req(bus.req), .last(last), .gnt(win_gnt), .idx(win_idx), .valid(win_valid)
  );
  assign sel_addr = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;
  // Returns are only accepted while a fill is in flight; strays in IDLE/WRITE are dropped.
  always_comb begin
    ret = bus.mem_valid && (state == ST_ISSUE || state == ST_DRAIN);
    last_ret = ret && ret_cnt == CW'(BURST_LEN - 1);
    state_n = state;
    if (state == ST_IDLE && win_valid) state_n = bus.req_wr[win_idx] ? ST_WRITE : ST_ISSUE;
    else if (state == ST_WRITE || last_ret) state_n = ST_IDLE;
    else if (state == ST_ISSUE && iss_cnt == CW'(BURST_LEN - 1)) state_n = ST_DRAIN;
    bus.gnt = owner;
    bus.done = (state == ST_WRITE || last_ret) ? owner : '0;
    bus.rsp_valid = ret ? owner : '0;
    bus.rsp_data = ret ? bus.mem_rdata : '0;
    bus.rsp_idx = ret ? ret_cnt : '0;
    bus.mem_en = state == ST_ISSUE || state == ST_WRITE;
    bus.mem_wr = state == ST_WRITE;
    bus.mem_addr = state == ST_ISSUE ? addr + ADDR_W'(iss_cnt) * ADDR_W'(WORD_BYTES) :
                   state == ST_WRITE ? addr : '0;
    bus.mem_wdata = state == ST_WRITE ? wdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner <= '0;
      last <= '0;
      addr <= '0;
      wdata <= '0;
      iss_cnt <= '0;
      ret_cnt <= '0;
    end else if (state == ST_IDLE) begin
      iss_cnt <= '0;
      ret_cnt <= '0;
      if (win_valid) begin
        owner <= win_gnt;
        last <= win_idx;
        addr <= bus.req_wr[win_idx] ? sel_addr : sel_addr & ~ADDR_W'(BURST_LEN * WORD_BYTES - 1);
        wdata <= bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
      end
    end else begin
      if (state == ST_ISSUE) iss_cnt <= iss_cnt + 1'b1;
      if (ret) ret_cnt <= ret_cnt + 1'b1;
      if (state == ST_WRITE || last_ret) owner <= '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scenarios against a transaction-level model of the arbiter
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  int lat0 = 2, cyc0 = 0, cyc1 = 0;
  logic v0 [16] = '{default: 1'b0};
  logic v1 [16] = '{default: 1'b0};
  logic [15:0] d0 [16], d1 [16];
  logic inj_v = 1'b0;
  logic [15:0] inj_d = 16'h0;
  logic [15:0] ra [2], rd [2];
  logic rw [2];

  mem_arbiter_if if0 ();
  mem_arbiter_if if1 ();
  mem_arbiter #(.RR_MODE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mem_arbiter #(.RR_MODE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  function automatic logic [15:0] mdat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic int rr_next(input logic [1:0] p, input int last);
    for (int k = 1; k <= 2; k++) if (p[(last + k) % 2]) return (last + k) % 2;
    return last;
  endfunction

  // Fixed-latency pipelined memory: a read issued in cycle t returns in cycle t+lat.
  always @(posedge clk) begin
    if (if0.mem_en && !if0.mem_wr) begin
      v0[(cyc0 + lat0) % 16] <= 1'b1;
      d0[(cyc0 + lat0) % 16] <= mdat(if0.mem_addr);
    end
    v0[cyc0 % 16] <= 1'b0;
    cyc0 <= cyc0 + 1;
  end
  assign if0.mem_valid = v0[cyc0 % 16] | inj_v;
  assign if0.mem_rdata = v0[cyc0 % 16] ? d0[cyc0 % 16] : inj_d;

  always @(posedge clk) begin
    if (if1.mem_en && !if1.mem_wr) begin
      v1[(cyc1 + 2) % 16] <= 1'b1;
      d1[(cyc1 + 2) % 16] <= mdat(if1.mem_addr);
    end
    v1[cyc1 % 16] <= 1'b0;
    cyc1 <= cyc1 + 1;
  end
  assign if1.mem_valid = v1[cyc1 % 16];
  assign if1.mem_rdata = d1[cyc1 % 16];

  task automatic apply(input int r);
    if0.req_wr[r] = rw[r];
    if0.req_addr[r*16 +: 16] = ra[r];
    if0.req_wdata[r*16 +: 16] = rd[r];
    if0.req[r] = 1'b1;
  endtask

  // Follows one granted transaction of requester r on dut0, checking it against ra/rd/rw.
  task automatic expect_txn(input int r, input bit drop);
    logic [15:0] base;
    logic [1:0] oh;
    int nis, nrs;
    bit fin;
    oh = 2'(1 << r);
    base = ra[r] & 16'hFFF0;
    for (int c = 0; c < 10 && if0.gnt == 2'b00; c++) @(negedge clk);
    checks++;
    if (if0.gnt !== oh) begin
      errors++;
      $display("FAIL grant r=%0d: got %b expected %b", r, if0.gnt, oh);
    end
    if (rw[r]) begin
      checks++;
      if ({if0.mem_en, if0.mem_wr, if0.mem_addr, if0.mem_wdata, if0.done, if0.rsp_valid} !==
          {1'b1, 1'b1, ra[r], rd[r], oh, 2'b00}) begin
        errors++;
        $display("FAIL write r=%0d: got en=%b wr=%b addr=%h wdata=%h done=%b rsp=%b expected 1 1 %h %h %b 00",
                 r, if0.mem_en, if0.mem_wr, if0.mem_addr, if0.mem_wdata, if0.done, if0.rsp_valid, ra[r], rd[r], oh);
      end
      if0.req[r] = 1'b0;
    end else begin
      if0.req_addr[r*16 +: 16] = 16'($urandom);
      if0.req_wdata[r*16 +: 16] = 16'($urandom);
      if (drop) if0.req[r] = 1'b0;
      nis = 0;
      nrs = 0;
      fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
        if (if0.mem_en) begin
          checks++;
          if (if0.mem_wr !== 1'b0 || if0.mem_addr !== base + 16'(2 * nis) || c != nis) begin
            errors++;
            $display("FAIL issue %0d: got wr=%b addr=%h cycle=%0d expected wr=0 addr=%h cycle=%0d",
                     nis, if0.mem_wr, if0.mem_addr, c, base + 16'(2 * nis), nis);
          end
          nis++;
        end
        if (if0.rsp_valid != 2'b00) begin
          checks++;
          if (if0.rsp_valid !== oh || if0.rsp_idx !== 3'(nrs) || if0.rsp_data !== mdat(base + 16'(2 * nrs))) begin
            errors++;
            $display("FAIL return %0d: got valid=%b idx=%0d data=%h expected %b %0d %h",
                     nrs, if0.rsp_valid, if0.rsp_idx, if0.rsp_data, oh, nrs, mdat(base + 16'(2 * nrs)));
          end
          nrs++;
        end
        if (if0.done != 2'b00) begin
          checks++;
          fin = 1'b1;
          if (if0.done !== oh || nis != 8 || nrs != 8 || if0.rsp_valid !== oh) begin
            errors++;
            $display("FAIL fill done: got done=%b issues=%0d returns=%0d expected %b 8 8", if0.done, nis, nrs, oh);
          end
          if0.req[r] = 1'b0;
        end else @(negedge clk);
      end
      if (!fin) begin
        checks++;
        errors++;
        $display("FAIL fill timeout: got issues=%0d returns=%0d expected done", nis, nrs);
      end
    end
    @(negedge clk);
    checks++;
    if (if0.gnt !== 2'b00 || if0.mem_en !== 1'b0 || if0.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL release: got gnt=%b en=%b rsp=%b expected 00 0 00", if0.gnt, if0.mem_en, if0.rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      checks++;
      if ({if0.gnt, if0.rsp_valid, if0.rsp_data, if0.rsp_idx, if0.done, if0.mem_en, if0.mem_wr, if0.mem_addr,
           if0.mem_wdata, if1.gnt, if1.done, if1.mem_en, if1.mem_addr} !== '0) begin
        errors++;
        $display("FAIL reset outputs (phase %0d): got gnt=%b en=%b addr=%h expected all zero", n, if0.gnt, if0.mem_en, if0.mem_addr);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_fixed_priority();
    lat0 = 2;
    ra[0] = 16'h0104; ra[1] = 16'h2008;
    rw[0] = 1'b0; rw[1] = 1'b0;
    rd[0] = 16'($urandom); rd[1] = 16'($urandom);
    apply(0);
    apply(1);
    expect_txn(0, 1'b0);
    expect_txn(1, 1'b0);
  endtask

  task automatic test_write();
    rw[1] = 1'b1; ra[1] = 16'h3A05; rd[1] = 16'hBEEF;
    inj_v = 1'b1; inj_d = 16'h1234;
    apply(1);
    expect_txn(1, 1'b0);
    inj_v = 1'b0;
    rw[1] = 1'b0;
  endtask

  task automatic test_fill_latency();
    lat0 = 4;
    ra[0] = 16'($urandom); rw[0] = 1'b0;
    apply(0);
    expect_txn(0, 1'b0);
  endtask

  task automatic test_reset_abort();
    lat0 = 4;
    ra[0] = 16'($urandom); rw[0] = 1'b0;
    apply(0);
    for (int c = 0; c < 10 && if0.gnt == 2'b00; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if0.gnt, if0.rsp_valid, if0.done, if0.mem_en, if0.mem_wr, if0.mem_addr, if0.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL abort: got gnt=%b en=%b addr=%h expected zeros", if0.gnt, if0.mem_en, if0.mem_addr);
    end
    if0.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      inj_v = c[0];
      inj_d = 16'($urandom);
      #1;
      checks++;
      if (if0.rsp_valid !== 2'b00 || if0.gnt !== 2'b00) begin
        errors++;
        $display("FAIL stale return %0d: got rsp=%b gnt=%b expected 00 00", c, if0.rsp_valid, if0.gnt);
      end
      @(negedge clk);
    end
    inj_v = 1'b0;
    ra[0] = 16'($urandom);
    apply(0);
    expect_txn(0, 1'b0);
  endtask

  task automatic test_req_drop();
    lat0 = 3;
    ra[0] = 16'($urandom); rw[0] = 1'b0;
    apply(0);
    expect_txn(0, 1'b1);
  endtask

  task automatic test_rr();
    int last;
    logic [1:0] exp;
    if1.req_wr = 2'b00;
    if1.req_addr = {16'h4010, 16'h1230};
    if1.req = 2'b01;
    for (int c = 0; c < 10 && if1.gnt == 2'b00; c++) @(negedge clk);
    checks++;
    if (if1.gnt !== 2'b01) begin
      errors++;
      $display("FAIL rr first grant: got %b expected 01", if1.gnt);
    end
    last = 0;
    if1.req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 40 && if1.done == 2'b00; c++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (if1.gnt !== 2'b00) begin
        errors++;
        $display("FAIL rr gap %0d: got %b expected 00", t, if1.gnt);
      end
      @(negedge clk);
      last = rr_next(2'b11, last);
      exp = 2'(1 << last);
      checks++;
      if (if1.gnt !== exp) begin
        errors++;
        $display("FAIL rr grant %0d: got %b expected %b", t + 1, if1.gnt, exp);
      end
    end
    if1.req = 2'b00;
    for (int c = 0; c < 40 && if1.done == 2'b00; c++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [1:0] pend;
      lat0 = $urandom_range(1, 6);
      for (int r = 0; r < 2; r++) begin
        rw[r] = 1'($urandom_range(0, 1));
        ra[r] = 16'($urandom);
        rd[r] = 16'($urandom);
      end
      pend = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) if (pend[r]) apply(r);
      while (pend != 2'b00) begin
        int w;
        w = pend[0] ? 0 : 1;
        expect_txn(w, 1'b0);
        pend[w] = 1'b0;
      end
    end
  endtask

  initial begin
    if0.req = '0; if0.req_wr = '0; if0.req_addr = '0; if0.req_wdata = '0;
    if1.req = '0; if1.req_wr = '0; if1.req_addr = '0; if1.req_wdata = '0;
    test_reset();
    test_fixed_priority();
    test_write();
    test_fill_latency();
    test_reset_abort();
    test_req_drop();
    test_rr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
